// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with one-level exception context
module pc_sequencer #(
  parameter int          PC_WIDTH     = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                BRANCH_TAKEN,
  input  logic [15:0]         IMM16,
  input  logic                JUMP,
  input  logic [25:0]         TGT26,
  input  logic                JR,
  input  logic [PC_WIDTH-1:0] JR_ADDR,
  input  logic                EXC_REQ,
  input  logic                ERET,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] PC_PLUS4,
  output logic [PC_WIDTH-1:0] EPC,
  output logic [1:0]          CAUSE,
  output logic                IN_EXC,
  output logic                HALTED
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EXC  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] RST_PC   = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] EXC_PC   = PC_WIDTH'(EXC_VECTOR);
  localparam logic [PC_WIDTH-1:0] PC_STEP  = PC_WIDTH'(4);
  localparam logic [1:0]          CAUSE_EXT = 2'b01;
  localparam logic [1:0]          CAUSE_MIS = 2'b10;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   epc_q, epc_d;
  logic [1:0]            cause_q, cause_d;

  logic [PC_WIDTH-1:0]   pc_plus4;
  logic [PC_WIDTH-1:0]   br_off;
  logic [PC_WIDTH-1:0]   flow_pc;
  logic                  misaligned_jr;
  logic                  fault;

  always_comb begin
    pc_plus4      = pc_q + PC_STEP;
    br_off        = {{(PC_WIDTH-18){IMM16[15]}}, IMM16, 2'b00};
    misaligned_jr = JR && (JR_ADDR[1:0] != 2'b00);
    fault         = EXC_REQ || misaligned_jr;

    // Ordinary control flow, shared by RUN and by handler code running in EXC.
    if (JR)                flow_pc = JR_ADDR;
    else if (JUMP)         flow_pc = {pc_plus4[PC_WIDTH-1:28], TGT26, 2'b00};
    else if (BRANCH_TAKEN) flow_pc = pc_plus4 + br_off;
    else                   flow_pc = pc_plus4;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;

    if (EN) begin
      case (state_q)
        ST_RUN: begin
          if (fault) begin
            epc_d   = pc_q;
            cause_d = misaligned_jr ? CAUSE_MIS : CAUSE_EXT;
            pc_d    = EXC_PC;
            state_d = ST_EXC;
          end else begin
            pc_d = flow_pc;
          end
        end
        ST_EXC: begin
          // A second fault while handling the first is unrecoverable; keep the first context.
          if (fault) begin
            state_d = ST_HALT;
          end else if (ERET) begin
            pc_d    = epc_q;
            cause_d = 2'b00;
            state_d = ST_RUN;
          end else begin
            pc_d = flow_pc;
          end
        end
        default: begin
          state_d = ST_HALT;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_RUN;
      pc_q    <= RST_PC;
      epc_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
    end
  end

  assign PC       = pc_q;
  assign PC_PLUS4 = pc_plus4;
  assign EPC      = epc_q;
  assign CAUSE    = cause_q;
  assign IN_EXC   = (state_q == ST_EXC);
  assign HALTED   = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks of pc_sequencer against a reference model
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EN;
  logic        BRANCH_TAKEN;
  logic [15:0] IMM16;
  logic        JUMP;
  logic [25:0] TGT26;
  logic        JR;
  logic [31:0] JR_ADDR;
  logic        EXC_REQ;
  logic        ERET;
  logic [31:0] PC, PC_PLUS4, EPC;
  logic [1:0]  CAUSE;
  logic        IN_EXC, HALTED;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_pc, m_epc;
  logic [1:0]  m_cause;
  bit          m_exc, m_halt;

  pc_sequencer dut (
    .CLK(CLK), .RST(RST), .EN(EN), .BRANCH_TAKEN(BRANCH_TAKEN), .IMM16(IMM16),
    .JUMP(JUMP), .TGT26(TGT26), .JR(JR), .JR_ADDR(JR_ADDR), .EXC_REQ(EXC_REQ),
    .ERET(ERET), .PC(PC), .PC_PLUS4(PC_PLUS4), .EPC(EPC), .CAUSE(CAUSE),
    .IN_EXC(IN_EXC), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},     PC,                 m_pc);
    check({tag, ".pc4"},    PC_PLUS4,           m_pc + 32'd4);
    check({tag, ".epc"},    EPC,                m_epc);
    check({tag, ".cause"},  {30'd0, CAUSE},     {30'd0, m_cause});
    check({tag, ".in_exc"}, {31'd0, IN_EXC},    {31'd0, m_exc});
    check({tag, ".halted"}, {31'd0, HALTED},    {31'd0, m_halt});
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_cause = 2'b00; m_exc = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step();
    bit mis;
    int signed woff;
    if (!EN || m_halt) return;
    mis  = JR && (JR_ADDR % 4 != 0);
    woff = $signed(IMM16);
    if (EXC_REQ || mis) begin
      if (m_exc) m_halt = 1'b1;
      else begin
        m_epc = m_pc; m_cause = mis ? 2'd2 : 2'd1; m_pc = 32'h180; m_exc = 1'b1;
      end
    end else if (ERET && m_exc) begin
      m_pc = m_epc; m_exc = 1'b0; m_cause = 2'd0;
    end else if (JR)           m_pc = JR_ADDR;
    else if (JUMP)             m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(TGT26) << 2);
    else if (BRANCH_TAKEN)     m_pc = m_pc + 32'd4 + 32'(woff * 4);
    else                       m_pc = m_pc + 32'd4;
    if (m_exc && m_halt) m_exc = 1'b0;
  endtask

  task automatic drive(input bit en, input bit br, input logic [15:0] imm, input bit j,
                       input logic [25:0] tgt, input bit jr, input logic [31:0] jra,
                       input bit exc, input bit eret);
    EN = en; BRANCH_TAKEN = br; IMM16 = imm; JUMP = j; TGT26 = tgt;
    JR = jr; JR_ADDR = jra; EXC_REQ = exc; ERET = eret;
  endtask

  task automatic idle();
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic goto_pc(input logic [31:0] a);
    drive(1, 0, 16'h0, 0, 26'h0, 1, a, 0, 0);
    tick("goto");
  endtask

  task automatic async_reset(input string tag);
    RST = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    RST = 1'b1;
  endtask

  initial begin
    RST = 1'b0;
    drive(0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    RST = 1'b1;

    idle();
    tick("seq1"); tick("seq2"); tick("seq3");
    check("seq3_abs", PC, 32'hC);
    async_reset("mid_rst");
    check("mid_rst_abs", PC, 32'h0);

    goto_pc(32'h100);
    drive(1, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0, 0);
    tick("br_back");
    check("br_back_abs", PC, 32'hFC);
    goto_pc(32'h1000_0000);
    drive(1, 0, 16'h0, 1, 26'h40, 0, 32'h0, 0, 0);
    tick("jump");
    check("jump_abs", PC, 32'h1000_0100);
    drive(1, 0, 16'h0, 1, 26'h40, 1, 32'h200, 0, 0);
    tick("jr_over_j");
    check("jr_over_j_abs", PC, 32'h200);

    drive(0, 0, 16'h0, 1, 26'h123, 0, 32'h0, 1, 0);
    tick("stall1"); tick("stall2");
    check("stall_abs", PC, 32'h200);
    drive(1, 0, 16'h0, 1, 26'h123, 0, 32'h0, 1, 0);
    tick("stall_exc");
    check("stall_exc_abs", PC, 32'h180);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1);
    tick("stall_eret");

    goto_pc(32'h40);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 0);
    tick("exc");
    check("exc_epc_abs", EPC, 32'h40);
    check("exc_cause_abs", {30'd0, CAUSE}, 32'd1);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1);
    tick("eret");
    check("eret_abs", PC, 32'h40);
    idle();
    tick("to44");
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 1);
    tick("eret_run");
    check("eret_run_abs", PC, 32'h48);

    goto_pc(32'h60);
    drive(1, 0, 16'h0, 0, 26'h0, 1, 32'h202, 0, 0);
    tick("misjr");
    check("misjr_cause_abs", {30'd0, CAUSE}, 32'd2);
    check("misjr_epc_abs", EPC, 32'h60);
    drive(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 0);
    tick("dblfault");
    check("halt_abs", {31'd0, HALTED}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1, $urandom, 16'($urandom), $urandom, 26'($urandom), $urandom, $urandom,
            $urandom, $urandom);
      tick("halt_frozen");
    end
    check("halt_pc_abs", PC, 32'h180);
    async_reset("halt_rst");

    goto_pc(32'hFFFF_FFFC);
    idle();
    tick("wrap");
    check("wrap_abs", PC, 32'h0);
    goto_pc(32'hFFFF_FFFC);
    drive(1, 1, 16'h0001, 0, 26'h0, 0, 32'h0, 0, 0);
    tick("wrap_br");
    check("wrap_br_abs", PC, 32'h4);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] jra;
      jra = $urandom;
      if ($urandom_range(0, 3) != 0) jra[1:0] = 2'b00;
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, 16'($urandom),
            $urandom_range(0, 5) == 0, 26'($urandom), $urandom_range(0, 5) == 0, jra,
            $urandom_range(0, 24) == 0, $urandom_range(0, 4) == 0);
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 199) == 0)
        async_reset("rnd_rst");
      tick("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the single-cycle MIPS core. It replaces the bare PC register with next-PC selection covering sequential, branch, jump, jump-register, exception and exception-return, plus a pipeline-ready stall enable. It holds a one-level exception context (EPC, CAUSE) and a RUN/EXC/HALT state machine. It sits between the control/ALU outputs and the instruction-memory address port.

## Interface
- PC_WIDTH, 32: PC width in bits; must be ≥ 32.
- RESET_VECTOR, 32'h0000_0000: PC value loaded at reset, zero-extended to PC_WIDTH.
- EXC_VECTOR, 32'h0000_0180: handler entry address, zero-extended to PC_WIDTH.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  advance enable; low = stall.
- BRANCH_TAKEN  in  1  conditional branch resolved taken.
- IMM16  in  16  branch offset, in words, signed.
- JUMP  in  1  J/JAL pseudo-direct jump.
- TGT26  in  26  jump target field.
- JR  in  1  jump-register.
- JR_ADDR  in  PC_WIDTH  register target for JR.
- EXC_REQ  in  1  external exception/trap request.
- ERET  in  1  exception return.
- PC  out  PC_WIDTH  current instruction address (registered).
- PC_PLUS4  out  PC_WIDTH  PC + 4, combinational, for link writes.
- EPC  out  PC_WIDTH  saved exception PC (registered).
- CAUSE  out  2  2'b01 external exception, 2'b10 misaligned JR target, 2'b00 none.
- IN_EXC  out  1  state is EXC.
- HALTED  out  1  state is HALT.

## Operation
- States: RUN, EXC, HALT. Reset gives RUN, PC=RESET_VECTOR, EPC=0, CAUSE=0, IN_EXC=0, HALTED=0.
- All inputs are sampled only when EN=1. When EN=0, PC, EPC, CAUSE and state hold, and every request is dropped; nothing is queued.
- Internal fault: misaligned JR is JR=1 with JR_ADDR[1:0]≠0. Fault = EXC_REQ or misaligned JR.
- Next-PC priority when EN=1, highest first:
  1. Fault.
  2. ERET, only in EXC.
  3. JR.
  4. JUMP.
  5. BRANCH_TAKEN.
  6. Sequential.
- Fault in RUN: EPC←PC, CAUSE←2'b10 if misaligned JR (even when EXC_REQ is also high), else 2'b01. PC←EXC_VECTOR, state→EXC.
- Fault in EXC (double fault): state→HALT and PC holds. EPC and CAUSE hold their first-fault values.
- HALT: PC, EPC, CAUSE frozen; all inputs ignored. Only RST exits.
- ERET in EXC: PC←EPC, state→RUN, CAUSE←0. EPC holds.
- ERET in RUN: ignored; the lower-priority selection applies.
- JR (aligned): PC←JR_ADDR.
- JUMP: PC←{PC_PLUS4[PC_WIDTH-1:28], TGT26, 2'b00}.
- Branch: PC←PC_PLUS4 + (sign-extend(IMM16) << 2).
- Sequential: PC←PC_PLUS4.
- Arithmetic is modulo 2^PC_WIDTH. Wrap-around from all-ones−3 to 0 is legal and is not a fault.
- Multiple control requests in one cycle are resolved by the priority list alone; no error is flagged.

## Timing
- Every redirect takes effect at the next rising edge (1-cycle latency). PC is valid from clock-to-q.
- PC_PLUS4 is combinational from PC, valid in the same cycle.
- IN_EXC and HALTED are decoded directly from the state register. They change on the same edge as PC.
- RST assertion mid-operation forces the reset values immediately, asynchronously. After RST deasserts, the first rising edge loads RESET_VECTOR+4 if EN=1.
- EPC and CAUSE update on the same edge as the PC load of EXC_VECTOR.

## Test plan
- Reset, then 3 cycles with EN=1 and no requests → PC 0x0, 0x4, 0x8, 0xC; mid-run RST low → PC=0 immediately, EPC=0, CAUSE=0.
- At PC=0x100: BRANCH_TAKEN with IMM16=0xFFFE → PC=0xFC. JUMP with TGT26=0x0000040 at PC=0x1000_0000 → PC=0x1000_0100. Same cycle JR=1, JR_ADDR=0x200 plus JUMP → PC=0x200.
- EN=0 for 2 cycles with EXC_REQ=1 and JUMP=1 → PC, state, EPC unchanged. EN=1 → exception taken.
- At PC=0x40: EXC_REQ → PC=0x180, EPC=0x40, CAUSE=01, IN_EXC=1. Then ERET → PC=0x40, IN_EXC=0, CAUSE=00. ERET in RUN at PC=0x44 → PC=0x48.
- JR with JR_ADDR=0x202 at PC=0x60 → PC=0x180, EPC=0x60, CAUSE=10. Then EXC_REQ while in EXC → HALTED=1, PC=0x180 frozen for 10 cycles regardless of inputs, EPC=0x60, CAUSE=10. Then RST → RUN, PC=0.
- At PC=0xFFFF_FFFC with sequential step → PC=0x0 and no fault; with BRANCH_TAKEN, IMM16=0x0001 → PC=0x4.
